// File: rtl/ram64_fifo_pkg.sv
//============================================================================
// Package : ram64_fifo_pkg
// Brief   : Shared sizing and grant encoding for the 64x16 RAM FIFO controller.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package ram64_fifo_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

    localparam logic GRANT_PUSH = 1'b0;
    localparam logic GRANT_POP  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo_ptr_ctr.sv
//============================================================================
// Module : fifo_ptr_ctr
// Brief  : Wrapping ADDR_W-bit pointer with sync reset, clear and increment.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module fifo_ptr_ctr #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_ptr;

    // Natural binary overflow gives the 63 -> 0 wrap for a power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + c_one;
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/ram64_fifo_ctrl.sv
//============================================================================
// Module : ram64_fifo_ctrl
// Brief  : FIFO controller for a single-port 64x16 RAM with push/pop arbitration.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module ram64_fifo_ctrl #(
    parameter int DATA_W = ram64_fifo_pkg::DATA_W,
    parameter int ADDR_W = ram64_fifo_pkg::ADDR_W,
    parameter int DEPTH  = ram64_fifo_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_valid,
    output logic              pop_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_d_in,
    output logic              mem_w,
    output logic              mem_r,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_d_out
);

    import ram64_fifo_pkg::*;

    localparam int                   c_cnt_w    = ADDR_W + 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0]   c_cnt_full = c_cnt_w'(DEPTH);

    logic [c_cnt_w-1:0] r_count;
    logic               r_last_grant;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_valid;

    logic [ADDR_W-1:0]  w_wr_ptr;
    logic [ADDR_W-1:0]  w_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_can_push;
    logic               w_can_pop;
    logic               w_grant_push;
    logic               w_grant_pop;
    logic               w_active;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);

    assign w_can_push = push_valid & ~w_full;
    assign w_can_pop  = pop_valid  & ~w_empty;

    // On contention the side that did not win last time is served.
    assign w_grant_pop  = w_can_pop  & (~w_can_push | (r_last_grant == GRANT_PUSH));
    assign w_grant_push = w_can_push & (~w_can_pop  | (r_last_grant == GRANT_POP));

    assign w_active  = ~rst & ~flush;
    assign w_push_ok = w_grant_push & w_active;
    assign w_pop_ok  = w_grant_pop  & w_active;

    always_comb begin
        mem_en   = 1'b0;
        mem_w    = 1'b0;
        mem_r    = 1'b0;
        mem_add  = '0;
        mem_d_in = '0;
        if (w_push_ok) begin
            mem_en   = 1'b1;
            mem_w    = 1'b1;
            mem_add  = w_wr_ptr;
            mem_d_in = push_data;
        end else if (w_pop_ok) begin
            mem_en  = 1'b1;
            mem_r   = 1'b1;
            mem_add = w_rd_ptr;
        end
    end

    fifo_ptr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_push_ok),
        .ptr (w_wr_ptr)
    );

    fifo_ptr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_pop_ok),
        .ptr (w_rd_ptr)
    );

    // flush clears state like reset but leaves the last popped word visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_last_grant <= GRANT_PUSH;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else if (flush) begin
            r_count      <= '0;
            r_last_grant <= GRANT_PUSH;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_push_ok) begin
                r_count      <= r_count + c_cnt_one;
                r_last_grant <= GRANT_PUSH;
            end else if (w_pop_ok) begin
                r_count      <= r_count - c_cnt_one;
                r_last_grant <= GRANT_POP;
                r_rd_data    <= mem_d_out;
            end
        end
    end

    assign push_ready = w_push_ok;
    assign pop_ready  = w_pop_ok;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_ram64_fifo_ctrl.sv
//============================================================================
// Module : tb_ram64_fifo_ctrl
// Brief  : Bench for ram64_fifo_ctrl with a behavioural RAM and queue model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_ram64_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic [15:0] push_data;
    logic        push_ready;
    logic        pop_valid;
    logic        pop_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [6:0]  count;
    logic        full;
    logic        empty;
    logic [5:0]  mem_add;
    logic [15:0] mem_d_in;
    logic        mem_w;
    logic        mem_r;
    logic        mem_en;
    logic [15:0] mem_d_out;

    logic [15:0] ram [0:63];

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [15:0] q[$];
    bit          m_last_pop;
    int          m_wptr;
    int          m_rptr;
    logic [15:0] m_rd_data;
    logic        m_rd_valid;

    ram64_fifo_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .mem_add    (mem_add),
        .mem_d_in   (mem_d_in),
        .mem_w      (mem_w),
        .mem_r      (mem_r),
        .mem_en     (mem_en),
        .mem_d_out  (mem_d_out)
    );

    // single-port RAM: write on edge, combinational read, idle pattern otherwise
    always @(posedge clk) begin
        if (mem_en && mem_w) ram[mem_add] <= mem_d_in;
    end
    assign mem_d_out = (mem_en && mem_r) ? ram[mem_add] : 16'hBAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic pv,
                        input logic [15:0] pd, input logic ov);
        bit cp, co, gpush, gpop, act;
        @(negedge clk);
        rst = r; flush = fl; push_valid = pv; push_data = pd; pop_valid = ov;
        act   = !r && !fl;
        cp    = pv && (q.size() < 64);
        co    = ov && (q.size() > 0);
        gpush = act && cp && (!co || m_last_pop);
        gpop  = act && co && (!cp || !m_last_pop);
        #1;
        chk("push_ready", {31'd0, push_ready}, {31'd0, gpush});
        chk("pop_ready",  {31'd0, pop_ready},  {31'd0, gpop});
        chk("mem_ctl", {29'd0, mem_en, mem_w, mem_r},
            {29'd0, (gpush || gpop), gpush, gpop});
        chk("mem_add", {26'd0, mem_add},
            gpush ? 32'(m_wptr) : (gpop ? 32'(m_rptr) : 32'd0));
        chk("mem_d_in", {16'd0, mem_d_in}, gpush ? {16'd0, pd} : 32'd0);
        @(posedge clk);
        if (r || fl) begin
            q.delete();
            m_last_pop = 1'b0;
            m_wptr = 0;
            m_rptr = 0;
            m_rd_valid = 1'b0;
            if (r) m_rd_data = 16'h0000;
        end else if (gpush) begin
            q.push_back(pd);
            m_last_pop = 1'b0;
            m_wptr = (m_wptr + 1) % 64;
            m_rd_valid = 1'b0;
        end else if (gpop) begin
            m_rd_data = q.pop_front();
            m_last_pop = 1'b1;
            m_rptr = (m_rptr + 1) % 64;
            m_rd_valid = 1'b1;
        end else begin
            m_rd_valid = 1'b0;
        end
        #1;
        chk("count",    {25'd0, count},    32'(q.size()));
        chk("full",     {31'd0, full},     {31'd0, q.size() == 64});
        chk("empty",    {31'd0, empty},    {31'd0, q.size() == 0});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
        chk("rd_data",  {16'd0, rd_data},  {16'd0, m_rd_data});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic push(input logic [15:0] d);
        step(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_valid = 1'b0;
        m_last_pop = 1'b0; m_wptr = 0; m_rptr = 0; m_rd_data = '0; m_rd_valid = 1'b0;

        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
        idle();

        // fill to full, then a rejected 65th push
        for (int i = 1; i <= 64; i++) push(16'(i));
        push(16'h0041);
        chk("ram_not_overwritten", {16'd0, ram[0]}, 32'h0001);

        // drain in order, then a rejected pop on empty
        for (int i = 0; i < 64; i++) pop();
        pop();
        idle();

        // pointer wrap
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) push(16'hA000 + 16'(k * 40 + i));
            for (int i = 0; i < 40; i++) pop();
        end
        idle();

        // contention at count 10
        for (int i = 0; i < 10; i++) push(16'hC000 + 16'(i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'hC100 + 16'(i), 1'b1);
        idle();

        // flush with a pop request at count 5
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) push(16'hD000 + 16'(i));
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        push(16'h1234);
        pop();
        idle();

        // reset mid-stream at count 20
        for (int i = 0; i < 20; i++) push(16'hE000 + 16'(i));
        step(1'b1, 1'b0, 1'b1, 16'hEEEE, 1'b1);
        idle();

        // randomized traffic with alternating fill/drain bias
        for (int c = 0; c < 3000; c++) begin
            bit r, fl, pv, ov, fill;
            fill = ((c / 250) % 2) == 0;
            r  = ($urandom % 300) == 0;
            fl = ($urandom % 80) == 0;
            pv = fill ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            ov = fill ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            step(r, fl, pv, 16'($urandom), ov);
        end
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
